// File: rtl/dram_port_arbiter_if.sv
// Bundle of signals between the two requesters, the arbiter and the
// DRAM controller host port.
//
// Handshakes:
//  - Requester side: REQ is held high with ADDR/RWn/WDATA stable until ACK
//    (a one-cycle pulse). REQ drops in the cycle after ACK. A REQ still high
//    when the arbiter is idle again is treated as a new transaction.
//    RDATA is valid with ACK and holds until the next read on that port.
//  - Controller side: CSn low marks an active transaction with addr/RWn/DOUT
//    stable. RDY is a one-cycle completion strobe, and DIN is sampled with it.
//
// Modports:
//  - master: the arbiter. It is master of the controller bus.
//  - slave:  the environment, i.e. the requesters plus the controller.
interface dram_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    // port A (CPU)
    logic          A_REQ;
    logic          A_RWn;
    logic [AW-1:0] A_ADDR;
    logic [DW-1:0] A_WDATA;
    logic          A_ACK;
    logic [DW-1:0] A_RDATA;

    // port B (DMA / video fetch)
    logic          B_REQ;
    logic          B_RWn;
    logic [AW-1:0] B_ADDR;
    logic [DW-1:0] B_WDATA;
    logic          B_ACK;
    logic [DW-1:0] B_RDATA;

    // completion status shared by both ports
    logic          ERR;

    // controller host port
    logic [AW-1:0] addr;
    logic          CSn;
    logic          RWn;
    logic [DW-1:0] DOUT;
    logic [DW-1:0] DIN;
    logic          RDY;

    modport master (
        input  A_REQ, A_RWn, A_ADDR, A_WDATA,
        input  B_REQ, B_RWn, B_ADDR, B_WDATA,
        input  DIN, RDY,
        output A_ACK, A_RDATA, B_ACK, B_RDATA, ERR,
        output addr, CSn, RWn, DOUT
    );

    modport slave (
        output A_REQ, A_RWn, A_ADDR, A_WDATA,
        output B_REQ, B_RWn, B_ADDR, B_WDATA,
        output DIN, RDY,
        input  A_ACK, A_RDATA, B_ACK, B_RDATA, ERR,
        input  addr, CSn, RWn, DOUT
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter in front of the DRAM controller host port.
// One transaction is in flight at a time. Every transaction is bounded by an
// RDY watchdog: if RDY does not arrive within TIMEOUT cycles, the transaction
// is closed with ACK+ERR so that a requester never hangs.
// All outputs come straight from flops.
// TIMEOUT must be at least 2.
module dram_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 RESET,
    dram_port_arbiter_if.master  bus,
    output logic [1:0]           dbg_state
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          grant_b, grant_b_n;   // port that owns the active transaction
    logic          last_b, last_b_n;     // port served most recently
    logic          pick_b;               // arbitration result in IDLE
    logic          finish;               // BUSY ends this cycle (RDY or timeout)

    logic [AW-1:0] addr_q, addr_n;
    logic          csn_q, csn_n;
    logic          rwn_q, rwn_n;
    logic [DW-1:0] dout_q, dout_n;
    logic          a_ack_q, a_ack_n;
    logic          b_ack_q, b_ack_n;
    logic          err_q, err_n;
    logic [DW-1:0] a_rdata_q, a_rdata_n;
    logic [DW-1:0] b_rdata_q, b_rdata_n;

    // Arbitration: a lone request wins. On a tie, the port not served last wins.
    always_comb begin
        pick_b = 1'b0;
        if (bus.A_REQ && bus.B_REQ) begin
            pick_b = ~last_b;
        end else begin
            pick_b = bus.B_REQ;
        end
    end

    // Next-state and next-output logic. Every output flop gets its next value here.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        grant_b_n = grant_b;
        last_b_n  = last_b;
        addr_n    = addr_q;
        csn_n     = csn_q;
        rwn_n     = rwn_q;
        dout_n    = dout_q;
        a_ack_n   = 1'b0;
        b_ack_n   = 1'b0;
        err_n     = 1'b0;
        a_rdata_n = a_rdata_q;
        b_rdata_n = b_rdata_q;
        finish    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.A_REQ || bus.B_REQ) begin
                    // Latch the winner's command. The command then stays
                    // frozen on the controller bus for the whole of BUSY.
                    grant_b_n = pick_b;
                    addr_n    = pick_b ? bus.B_ADDR  : bus.A_ADDR;
                    rwn_n     = pick_b ? bus.B_RWn   : bus.A_RWn;
                    dout_n    = pick_b ? bus.B_WDATA : bus.A_WDATA;
                    csn_n     = 1'b0;
                    cnt_n     = '0;
                    state_n   = BUSY;
                end
            end

            BUSY: begin
                cnt_n = cnt + 1'b1;
                if (bus.RDY) begin
                    // RDY takes priority over a timeout in the same cycle.
                    finish = 1'b1;
                    if (rwn_q) begin
                        if (grant_b) begin
                            b_rdata_n = bus.DIN;
                        end else begin
                            a_rdata_n = bus.DIN;
                        end
                    end
                end else if (cnt == CNT_LAST) begin
                    // Watchdog expired: close the transaction. RDATA is not touched.
                    finish = 1'b1;
                    err_n  = 1'b1;
                end

                if (finish) begin
                    csn_n    = 1'b1;
                    a_ack_n  = ~grant_b;
                    b_ack_n  = grant_b;
                    last_b_n = grant_b;
                    state_n  = RELEASE;
                end
            end

            RELEASE: begin
                // One deselected cycle. This is also the cycle in which ACK/ERR are visible.
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
                csn_n   = 1'b1;
            end
        endcase
    end

    // State and output registers. Reset aborts any transaction without an ACK.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            grant_b   <= 1'b0;
            last_b    <= 1'b1;          // B counts as served last, so A wins the first tie
            addr_q    <= '0;
            csn_q     <= 1'b1;
            rwn_q     <= 1'b1;
            dout_q    <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            grant_b   <= grant_b_n;
            last_b    <= last_b_n;
            addr_q    <= addr_n;
            csn_q     <= csn_n;
            rwn_q     <= rwn_n;
            dout_q    <= dout_n;
            a_ack_q   <= a_ack_n;
            b_ack_q   <= b_ack_n;
            err_q     <= err_n;
            a_rdata_q <= a_rdata_n;
            b_rdata_q <= b_rdata_n;
        end
    end

    assign bus.addr    = addr_q;
    assign bus.CSn     = csn_q;
    assign bus.RWn     = rwn_q;
    assign bus.DOUT    = dout_q;
    assign bus.A_ACK   = a_ack_q;
    assign bus.B_ACK   = b_ack_q;
    assign bus.ERR     = err_q;
    assign bus.A_RDATA = a_rdata_q;
    assign bus.B_RDATA = b_rdata_q;

    assign dbg_state   = state;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed scenarios, then randomized
// transactions, all checked against a transaction-level model of the arbiter.
module tb_dram_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       RESET;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    // transaction-level model state
    bit            last_b;        // port served most recently
    logic [DW-1:0] a_rd_m;
    logic [DW-1:0] b_rd_m;
    bit            last_obs_b;    // port that the DUT actually acknowledged

    dram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // overall time limit
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction, starting at a negedge in which the DUT is idle.
    // lat = the BUSY cycle in which RDY is returned (lat > TO means RDY never comes).
    task automatic txn(input bit ra, input bit rb, input int lat,
                       input bit a_rw, input logic [AW-1:0] a_ad, input logic [DW-1:0] a_wd,
                       input bit b_rw, input logic [AW-1:0] b_ad, input logic [DW-1:0] b_wd,
                       input logic [DW-1:0] din);
        bit            win_b;
        bit            e_rw;
        bit            exp_err;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dout;
        int            n;
        int            k;
        int            exp_low;

        // Model: a lone request wins; on a tie, the port not served last wins.
        win_b   = (ra && rb) ? !last_b : rb;
        e_addr  = win_b ? b_ad : a_ad;
        e_rw    = win_b ? b_rw : a_rw;
        e_dout  = win_b ? b_wd : a_wd;
        exp_err = (lat > TO);
        exp_low = exp_err ? TO : lat;

        bus.A_REQ = ra;   bus.B_REQ = rb;
        bus.A_RWn = a_rw; bus.A_ADDR = a_ad; bus.A_WDATA = a_wd;
        bus.B_RWn = b_rw; bus.B_ADDR = b_ad; bus.B_WDATA = b_wd;

        // A stray RDY while the DUT is idle must have no effect.
        if ($urandom_range(0, 3) == 0) begin
            bus.RDY = 1'b1;
            bus.DIN = 8'($urandom);
            @(posedge clk);
            #1;
            bus.RDY = 1'b0;
        end

        n = 0;
        @(negedge clk);
        while (bus.CSn !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("issue_latency", n, 0);
        if (n >= 20) begin
            bus.A_REQ = 1'b0;
            bus.B_REQ = 1'b0;
            return;
        end

        k = 1;
        forever begin
            chk("busy_csn",  32'(bus.CSn), 0);
            chk("busy_addr", 32'(bus.addr), 32'(e_addr));
            chk("busy_rwn",  32'(bus.RWn), 32'(e_rw));
            chk("busy_dout", 32'(bus.DOUT), 32'(e_dout));
            chk("busy_ack",  32'({bus.A_ACK, bus.B_ACK, bus.ERR}), 0);
            if (k == lat) begin
                bus.RDY = 1'b1;
                bus.DIN = din;
            end
            // Port inputs wander during BUSY; the active transaction must ignore them.
            bus.A_ADDR  = 16'($urandom); bus.B_ADDR  = 16'($urandom);
            bus.A_WDATA = 8'($urandom);  bus.B_WDATA = 8'($urandom);
            bus.A_RWn   = 1'($urandom);  bus.B_RWn   = 1'($urandom);
            if (win_b) bus.A_REQ = 1'($urandom); else bus.B_REQ = 1'($urandom);
            @(posedge clk);
            #1;
            bus.RDY = 1'b0;
            bus.DIN = 8'($urandom);
            @(negedge clk);
            if (bus.CSn !== 1'b0 || k >= TO + 2) break;
            k++;
        end

        // release cycle: ACK/ERR visible, bus deselected
        if (!exp_err && e_rw) begin
            if (win_b) b_rd_m = din; else a_rd_m = din;
        end
        last_b     = win_b;
        last_obs_b = bus.B_ACK;
        chk("csn_low_cycles", k, exp_low);
        chk("rel_csn",   32'(bus.CSn), 1);
        chk("rel_a_ack", 32'(bus.A_ACK), 32'(!win_b));
        chk("rel_b_ack", 32'(bus.B_ACK), 32'(win_b));
        chk("rel_err",   32'(bus.ERR), 32'(exp_err));
        chk("a_rdata",   32'(bus.A_RDATA), 32'(a_rd_m));
        chk("b_rdata",   32'(bus.B_RDATA), 32'(b_rd_m));

        // winner drops REQ after its ACK; the loser returns to its request
        if (win_b) begin bus.B_REQ = 1'b0; bus.A_REQ = ra; end
        else       begin bus.A_REQ = 1'b0; bus.B_REQ = rb; end

        @(negedge clk);
        chk("gap_csn", 32'(bus.CSn), 1);
        chk("gap_ack", 32'({bus.A_ACK, bus.B_ACK, bus.ERR}), 0);
    endtask

    initial begin
        int n;
        bit ra;
        bit rb;

        // reset
        RESET = 1'b1;
        bus.A_REQ = 1'b0; bus.A_RWn = 1'b1; bus.A_ADDR = '0; bus.A_WDATA = '0;
        bus.B_REQ = 1'b0; bus.B_RWn = 1'b1; bus.B_ADDR = '0; bus.B_WDATA = '0;
        bus.RDY = 1'b0;   bus.DIN = '0;
        last_b = 1'b1; a_rd_m = '0; b_rd_m = '0; last_obs_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_csn",  32'(bus.CSn), 1);
        chk("rst_rwn",  32'(bus.RWn), 1);
        chk("rst_addr", 32'(bus.addr), 0);
        chk("rst_dout", 32'(bus.DOUT), 0);
        chk("rst_acks", 32'({bus.A_ACK, bus.B_ACK, bus.ERR}), 0);
        chk("rst_rdata", 32'({bus.A_RDATA, bus.B_RDATA}), 0);
        RESET = 1'b0;

        // single A read, RDY in the third BUSY cycle
        txn(1, 0, 3, 1, 16'h1234, 8'h00, 1, 16'h0000, 8'h00, 8'h5A);
        chk("a_read_data", 32'(bus.A_RDATA), 32'h5A);

        // single B write
        txn(0, 1, 2, 1, 16'h0000, 8'h00, 0, 16'hBEEF, 8'hC3, 8'h99);
        chk("b_write_a_rdata", 32'(bus.A_RDATA), 32'h5A);
        chk("b_write_b_rdata", 32'(bus.B_RDATA), 32'h00);

        // both ports requesting continuously: A, B, A, B
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 1, 1, 16'($urandom), 8'($urandom), 1, 16'($urandom), 8'($urandom), 8'($urandom));
            chk("fair_order", 32'(last_obs_b), 32'(i % 2));
        end

        // timeout: RDY never arrives, then a normal transaction
        txn(1, 0, 100, 1, 16'h0A0A, 8'h11, 1, 16'h0000, 8'h00, 8'hEE);
        txn(1, 0, 2, 1, 16'h0B0B, 8'h22, 1, 16'h0000, 8'h00, 8'h77);

        // RDY exactly on the last watchdog cycle: RDY wins
        txn(0, 1, TO, 1, 16'h0000, 8'h00, 1, 16'h0C0C, 8'h33, 8'hA5);
        chk("last_cycle_rdata", 32'(bus.B_RDATA), 32'hA5);

        // reset in the middle of BUSY
        bus.A_REQ = 1'b1; bus.A_RWn = 1'b1; bus.A_ADDR = 16'h0042; bus.B_REQ = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.CSn !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_busy", 32'(bus.CSn), 0);
        @(negedge clk);
        RESET = 1'b1;
        #1;
        chk("async_rst_csn",  32'(bus.CSn), 1);
        chk("async_rst_acks", 32'({bus.A_ACK, bus.B_ACK, bus.ERR}), 0);
        chk("async_rst_rdata", 32'({bus.A_RDATA, bus.B_RDATA}), 0);
        last_b = 1'b1; a_rd_m = '0; b_rd_m = '0;
        @(negedge clk);
        chk("rst_no_ack", 32'({bus.A_ACK, bus.B_ACK}), 0);
        RESET = 1'b0;
        txn(1, 1, 2, 1, 16'h0042, 8'h00, 1, 16'h0043, 8'h00, 8'h3C);
        chk("post_rst_first", 32'(last_obs_b), 0);

        // randomized transactions
        for (int i = 0; i < 40; i++) begin
            ra = 1'($urandom);
            rb = 1'($urandom);
            if (!ra && !rb) ra = 1'b1;
            txn(ra, rb, int'($urandom_range(1, TO + 2)),
                1'($urandom), 16'($urandom), 8'($urandom),
                1'($urandom), 16'($urandom), 8'($urandom),
                8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
